// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, parity modes and the
// baud-divider counter width helper, common to the tx and rx blocks.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_ODD  = 1;
  localparam int unsigned PARITY_EVEN = 2;

  // Width of a counter running 0..div-1 (at least one bit).
  function automatic int unsigned div_width(input int unsigned div);
    return (div < 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period divider: counts 0..DIV-1 and pulses tick on DIV-1.
// restart clears the count so a new frame starts with a full bit period.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned DIV = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int unsigned W = div_width(DIV);

  logic [W-1:0] cnt_q;

  // Free-running bit-period counter with synchronous restart.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (restart || (cnt_q == W'(DIV - 1))) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign tick = (cnt_q == W'(DIV - 1));

endmodule

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter with internal baud divider and a
// valid/ready payload handshake. Frame: start, DATA_BITS LSB first,
// optional parity, STOP_BITS stop bits.
// Optional parity bit compiled in with `define UART_TX_PARITY_EN.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = 50_000_000,
  parameter int unsigned BAUD        = 9600,
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned STOP_BITS   = 1,
  parameter int unsigned PARITY_MODE = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic                 rs232_tx
);

  localparam int unsigned DIV = CLK_FREQ / BAUD;
  localparam int unsigned BW  = $clog2(DATA_BITS + 1);

  if (DIV < 2) begin : g_bad_div
    $error("uart_tx_frame: CLK_FREQ/BAUD must be at least 2");
  end
  if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_bad_data_bits
    $error("uart_tx_frame: DATA_BITS must be 5..9");
  end
  if ((STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_bad_stop_bits
    $error("uart_tx_frame: STOP_BITS must be 1 or 2");
  end
  if (PARITY_MODE > PARITY_EVEN) begin : g_bad_parity_mode
    $error("uart_tx_frame: PARITY_MODE must be 0, 1 or 2");
  end

`ifdef UART_TX_PARITY_EN
  localparam bit PAR_ON = (PARITY_MODE == PARITY_ODD) || (PARITY_MODE == PARITY_EVEN);
  logic par_q;
`endif

  uart_state_e          state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 line_q, line_d;
  logic                 done_q, done_d;
  logic                 accept;
  logic                 tick;

  assign accept = tx_valid && (state_q == IDLE);

  uart_baud_tick #(
    .DIV (DIV)
  ) u_baud (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (accept),
    .tick    (tick)
  );

  // Next-state, shift and line value; line_d is the value for the state
  // being entered so the registered line lines up with the state register.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    line_d     = 1'b1;
    case (state_q)
      IDLE: begin
        if (tx_valid) begin
          state_d    = START;
          shift_d    = tx_data;
          bit_cnt_d  = '0;
          stop_cnt_d = 1'b0;
        end
      end
      START: begin
        if (tick) state_d = DATA;
      end
      DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == BW'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_d = PAR_ON ? PARITY : STOP;
`else
            state_d = STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (tick) state_d = STOP;
      end
`endif
      STOP: begin
        if (tick) begin
          if (stop_cnt_q == 1'(STOP_BITS - 1)) state_d = IDLE;
          else                                  stop_cnt_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    case (state_d)
      START:   line_d = 1'b0;
      DATA:    line_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  line_d = par_q;
`endif
      default: line_d = 1'b1;
    endcase

    done_d = (state_q == STOP) && (state_d == IDLE);
  end

  // Frame state, datapath and registered line/done outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      line_q     <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      line_q     <= line_d;
      done_q     <= done_d;
    end
  end

`ifdef UART_TX_PARITY_EN
  // Parity taken from the payload at acceptance, before shifting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q <= 1'b0;
    end else if (accept) begin
      par_q <= (PARITY_MODE == PARITY_ODD) ? ~^tx_data : ^tx_data;
    end
  end
`endif

  assign rs232_tx = line_q;
  assign tx_done  = done_q;
  assign tx_busy  = (state_q != IDLE);
  assign tx_ready = (state_q == IDLE);

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame: an 8-bit/1-stop (even parity when
// enabled) instance and a 7-bit/2-stop (odd parity when enabled) instance,
// each compared every cycle against a waveform model built from frame bits.
module tb_uart_tx_frame;

  localparam int DIV     = 10;
`ifdef UART_TX_PARITY_EN
  localparam int PEN     = 1;
`else
  localparam int PEN     = 0;
`endif
  localparam int LEN_A   = DIV * (1 + 8 + PEN + 1);
  localparam int LEN_B   = DIV * (1 + 7 + PEN + 2);
  localparam int TIMEOUT = 2000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] a_data = '0;
  logic       a_valid = 1'b0;
  logic       a_ready, a_busy, a_done, a_line;
  logic [6:0] b_data = '0;
  logic       b_valid = 1'b0;
  logic       b_ready, b_busy, b_done, b_line;

  uart_tx_frame #(
    .CLK_FREQ    (50_000_000),
    .BAUD        (5_000_000),
    .DATA_BITS   (8),
    .STOP_BITS   (1),
    .PARITY_MODE (2)
  ) dut_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .tx_data  (a_data),
    .tx_valid (a_valid),
    .tx_ready (a_ready),
    .tx_busy  (a_busy),
    .tx_done  (a_done),
    .rs232_tx (a_line)
  );

  uart_tx_frame #(
    .CLK_FREQ    (50_000_000),
    .BAUD        (5_000_000),
    .DATA_BITS   (7),
    .STOP_BITS   (2),
    .PARITY_MODE (1)
  ) dut_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .tx_data  (b_data),
    .tx_valid (b_valid),
    .tx_ready (b_ready),
    .tx_busy  (b_busy),
    .tx_done  (b_done),
    .rs232_tx (b_line)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Serial bit sequence of one frame, index 0 = start bit; trailing ones are stop bits.
  function automatic logic [15:0] frame_bits(input logic [8:0] d, input int nb, input int pmode);
    logic [15:0] fb;
    logic        par;
    fb  = '1;
    fb[0] = 1'b0;
    par = 1'b0;
    for (int i = 0; i < nb; i++) begin
      fb[1 + i] = d[i];
      par ^= d[i];
    end
    if (PEN != 0 && pmode != 0) fb[1 + nb] = (pmode == 1) ? ~par : par;
    return fb;
  endfunction

  // Reference: k = cycles since accept (-1 idle); k==LEN is the done cycle.
  int          ka = -1, kb = -1;
  logic [15:0] fa = '1, fb_b = '1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ka <= -1;
    end else if ((ka < 0 || ka >= LEN_A) && a_valid) begin
      fa <= frame_bits({1'b0, a_data}, 8, 2);
      ka <= 0;
    end else if (ka >= 0) begin
      ka <= (ka >= LEN_A) ? -1 : ka + 1;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kb <= -1;
    end else if ((kb < 0 || kb >= LEN_B) && b_valid) begin
      fb_b <= frame_bits({2'b00, b_data}, 7, 1);
      kb <= 0;
    end else if (kb >= 0) begin
      kb <= (kb >= LEN_B) ? -1 : kb + 1;
    end
  end

  always @(negedge clk) begin
    check("a_line",  a_line,  (ka >= 0 && ka < LEN_A) ? fa[ka / DIV] : 1'b1);
    check("a_busy",  a_busy,  (ka >= 0 && ka < LEN_A));
    check("a_ready", a_ready, !(ka >= 0 && ka < LEN_A));
    check("a_done",  a_done,  (ka == LEN_A));
    check("b_line",  b_line,  (kb >= 0 && kb < LEN_B) ? fb_b[kb / DIV] : 1'b1);
    check("b_busy",  b_busy,  (kb >= 0 && kb < LEN_B));
    check("b_ready", b_ready, !(kb >= 0 && kb < LEN_B));
    check("b_done",  b_done,  (kb == LEN_B));
  end

  function automatic int kof(input bit sel);
    return sel ? kb : ka;
  endfunction

  task automatic drive(input bit sel, input logic [8:0] d, input logic v);
    if (sel) begin b_data = d[6:0]; b_valid = v; end
    else     begin a_data = d[7:0]; a_valid = v; end
  endtask

  // Wait (posedge + 1) until the model reports k == target.
  task automatic wait_k(input bit sel, input int target, input string tag);
    int n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (kof(sel) != target && n < TIMEOUT);
    check(tag, (n < TIMEOUT), 1'b1);
  endtask

  task automatic send(input bit sel, input logic [8:0] d);
    @(negedge clk);
    drive(sel, d, 1'b1);
    wait_k(sel, 0, sel ? "b_accept_wait" : "a_accept_wait");
    @(negedge clk);
    drive(sel, 9'($urandom), 1'b0);
  endtask

  task automatic wait_idle(input bit sel);
    int n = 0;
    while (kof(sel) >= 0 && n < TIMEOUT) begin
      @(negedge clk); n++;
    end
    check(sel ? "b_idle_wait" : "a_idle_wait", (n < TIMEOUT), 1'b1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_a_line",  a_line,  1'b1);
    check("rst_a_busy",  a_busy,  1'b0);
    check("rst_a_done",  a_done,  1'b0);
    check("rst_a_ready", a_ready, 1'b1);
    check("rst_b_line",  b_line,  1'b1);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // directed: 0xA5 on the 8-bit unit, 0xFF (bit 7 dropped) on the 7-bit unit
    send(1'b0, 9'h0A5);
    wait_idle(1'b0);
    send(1'b1, 9'h0FF);
    wait_idle(1'b1);

    // randomized frames on both units concurrently
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          send(1'b0, 9'($urandom));
          wait_idle(1'b0);
          repeat ($urandom_range(0, 3)) @(negedge clk);
        end
      end
      begin
        for (int j = 0; j < 5; j++) begin
          send(1'b1, 9'($urandom));
          wait_idle(1'b1);
          repeat ($urandom_range(0, 3)) @(negedge clk);
        end
      end
    join

    // back-to-back with valid held: second payload taken in the done cycle
    @(negedge clk);
    drive(1'b0, 9'h055, 1'b1);
    wait_k(1'b0, 0, "b2b_first_wait");
    a_data = 8'h0F;
    wait_k(1'b0, 0, "b2b_second_wait");
    @(negedge clk);
    a_valid = 1'b0;
    wait_idle(1'b0);

    // valid pulse while busy must be ignored
    send(1'b0, 9'h0C3);
    wait_k(1'b0, 30, "busy_pulse_wait");
    @(negedge clk);
    drive(1'b0, 9'h033, 1'b1);
    @(negedge clk);
    drive(1'b0, 9'h033, 1'b0);
    wait_idle(1'b0);

    // reset during data bit 3
    send(1'b0, 9'($urandom));
    wait_k(1'b0, 45, "mid_rst_wait");
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_line", a_line, 1'b1);
    check("mid_rst_busy", a_busy, 1'b0);
    check("mid_rst_done", a_done, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    send(1'b0, 9'h096);
    wait_idle(1'b0);
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
